pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised successor to the single-cycle program counter, with configurable width, reset vector and instruction size.
- Adds a stall input, a RUN/HALTED state machine with resume, and absolute jumps with optional link.
- Adds a return-address stack (RAS) of configurable depth for call/return, with sticky overflow/underflow flags.
- Drives the instruction memory address and feeds the instruction register.

Parameters:
XLEN, 32, width of PC and all target/address buses
RESET_VECTOR, 0, PC value loaded on reset (must be INSTR_BYTES-aligned)
INSTR_BYTES, 4, sequential increment; power of two >= 1
RAS_DEPTH, 4, return-address stack entries; >= 1

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
stall  input  1  hold PC and all state this cycle
is_halt  input  1  halt instruction decoded at current PC
resume  input  1  leave HALTED (ignored in RUN)
branch_taken  input  1  conditional branch resolved taken
branch_target  input  XLEN  branch destination
jump  input  1  unconditional jump
jump_target  input  XLEN  jump destination
link  input  1  with jump: push return address (call)
ret  input  1  return: pop RAS
pc_value  output  XLEN  current PC (registered)
pc_next  output  XLEN  value PC takes at next edge (combinational)
halted  output  1  1 in HALTED state (registered)
ras_count  output  $clog2(RAS_DEPTH+1)  valid RAS entries
ras_overflow  output  1  sticky: push occurred while full
ras_underflow  output  1  sticky: pop occurred while empty

Behaviour:
- Reset (async assert, reset_n=0):
  - pc_value=RESET_VECTOR, state RUN, halted=0, ras_count=0, both flags 0.
  - RAS entry contents are don't-care.
- Reset release: first rising edge with reset_n=1 evaluates normally.
- Reset asserted mid-operation overrides everything immediately, including HALTED and stall.
- Let seq = pc_value + INSTR_BYTES, computed modulo 2^XLEN; 2^XLEN-INSTR_BYTES wraps to 0.
- Target alignment: the low log2(INSTR_BYTES) bits of branch_target, jump_target and popped RAS values are forced to 0.
- States: RUN, HALTED.
- RUN with stall=1:
  - pc_next=pc_value.
  - No state, RAS or flag change.
  - All other inputs ignored, including is_halt.
- RUN with stall=0: fixed priority, evaluated in this order:
  1. is_halt: pc_next=pc_value; go to HALTED; halted=1 after the edge; RAS untouched.
  2. ret:
     - RAS non-empty: pc_next = top entry; pop; ras_count-1.
     - RAS empty: pc_next=seq; ras_underflow<=1; count stays 0.
     - jump, link and branch_taken are ignored in the same cycle.
  3. jump: pc_next=jump_target.
     - If link=1, push seq.
     - Full RAS: oldest entry is overwritten (circular), ras_count stays RAS_DEPTH, ras_overflow<=1.
  4. branch_taken: pc_next=branch_target.
  5. Otherwise: pc_next=seq.
- link without jump: ignored.
- HALTED:
  - pc_next=pc_value and PC holds; stall and control inputs are ignored.
  - resume=1: pc_next=seq; go to RUN; halted=0 after the edge.
  - resume and stall both high: resume wins, since stall is ignored in HALTED.
- Push and pop never occur in the same cycle.
- RAS is LIFO: the most recent push is popped first.
- Flags are sticky and cleared only by reset.
- Latency:
  - pc_value updates one cycle after the control inputs are sampled.
  - pc_next reflects the current inputs combinationally, with no registered delay.

Test Plan:
- Reset with RESET_VECTOR=0x100, reset_n low, then high for 4 idle cycles -> pc_value 0x100,0x104,0x108,0x10C,0x110; halted=0; ras_count=0.
- From pc_value=0x20: stall for 2 cycles, then branch_taken with target 0x43 -> PC holds at 0x20 for 2 cycles, then becomes 0x40.
- Call/return nesting:
  - Sequence: jump+link at 0x10 to 0x80, jump+link at 0x80 to 0xC0, ret, ret.
  - Required: PC 0x80, 0xC0, 0x84, 0x14; ras_count 1,2,1,0; no flags.
- RAS overflow (RAS_DEPTH=2):
  - Stimulus: calls from 0x0, 0x100, 0x200, then 3 rets.
  - Required: ras_overflow=1; pops return 0x204, 0x104.
  - Third ret underflows: ras_underflow=1 and PC=seq.
- Halt/resume and priority:
  - is_halt together with branch_taken at 0x30 -> PC holds at 0x30, halted=1; PC stays 0x30 for 5 cycles despite branches.
  - resume -> PC=0x34, halted=0.
  - ret together with jump -> ret wins.
- Wrap and async reset:
  - PC at 0xFFFFFFFC, idle -> PC becomes 0x0.
  - Assert reset_n mid-cycle while HALTED with flags set -> immediate RESET_VECTOR, halted=0, flags=0, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer with a RUN/HALTED controller, stall, branch and
// jump steering, and a circular return-address stack for call/return.
module pc_sequencer #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              INSTR_BYTES  = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           stall,
    input  logic                           is_halt,
    input  logic                           resume,
    input  logic                           branch_taken,
    input  logic [XLEN-1:0]                branch_target,
    input  logic                           jump,
    input  logic [XLEN-1:0]                jump_target,
    input  logic                           link,
    input  logic                           ret,
    output logic [XLEN-1:0]                pc_value,
    output logic [XLEN-1:0]                pc_next,
    output logic                           halted,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int              CW         = $clog2(RAS_DEPTH + 1);
    localparam int              PW         = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));
    localparam logic [CW-1:0]   FULL       = CW'(RAS_DEPTH);
    localparam logic [PW-1:0]   LAST       = PW'(RAS_DEPTH - 1);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] seq;
    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   ptr_inc;
    logic [PW-1:0]   ptr_dec;
    logic [XLEN-1:0] ras_top;
    logic            push;
    logic            pop;
    logic            set_ovf;
    logic            set_udf;

    // Force targets onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

    // wr_ptr is the next free slot; the top of stack sits just below it.
    // When full, wr_ptr also points at the oldest entry, so a push there
    // overwrites it circularly.
    assign seq     = pc_value + STEP;
    assign ptr_inc = (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
    assign ptr_dec = (wr_ptr == '0) ? LAST : wr_ptr - PW'(1);
    assign ras_top = align_target(ras_mem[ptr_dec]);
    assign halted  = (state == HALTED);

    // Next-state, next-PC and RAS control decode with fixed priority.
    always_comb begin
        state_next = state;
        pc_next    = pc_value;
        push       = 1'b0;
        pop        = 1'b0;
        set_ovf    = 1'b0;
        set_udf    = 1'b0;
        case (state)
            RUN: begin
                if (!stall) begin
                    if (is_halt) begin
                        state_next = HALTED;
                    end else if (ret) begin
                        if (ras_count != '0) begin
                            pc_next = ras_top;
                            pop     = 1'b1;
                        end else begin
                            pc_next = seq;
                            set_udf = 1'b1;
                        end
                    end else if (jump) begin
                        pc_next = align_target(jump_target);
                        if (link) begin
                            push    = 1'b1;
                            set_ovf = (ras_count == FULL);
                        end
                    end else if (branch_taken) begin
                        pc_next = align_target(branch_target);
                    end else begin
                        pc_next = seq;
                    end
                end
            end
            HALTED: begin
                if (resume) begin
                    pc_next    = seq;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Control state: PC, FSM state, stack pointer/count and sticky flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RUN;
            pc_value      <= RESET_VECTOR;
            wr_ptr        <= '0;
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            state    <= state_next;
            pc_value <= pc_next;
            if (push) begin
                wr_ptr <= ptr_inc;
                if (ras_count != FULL) ras_count <= ras_count + CW'(1);
            end else if (pop) begin
                wr_ptr    <= ptr_dec;
                ras_count <= ras_count - CW'(1);
            end
            if (set_ovf) ras_overflow  <= 1'b1;
            if (set_udf) ras_underflow <= 1'b1;
        end
    end

    // Stack storage holds return addresses only; no reset needed.
    always_ff @(posedge clock) begin
        if (push) ras_mem[wr_ptr] <= seq;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer (RESET_VECTOR=0x100, RAS_DEPTH=2).
module tb_pc_sequencer;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic        is_halt;
    logic        resume;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        link;
    logic        ret;
    logic [31:0] pc_value;
    logic [31:0] pc_next;
    logic        halted;
    logic [1:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer #(
        .XLEN(32),
        .RESET_VECTOR(32'h100),
        .INSTR_BYTES(4),
        .RAS_DEPTH(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .stall(stall),
        .is_halt(is_halt),
        .resume(resume),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_target(jump_target),
        .link(link),
        .ret(ret),
        .pc_value(pc_value),
        .pc_next(pc_next),
        .halted(halted),
        .ras_count(ras_count),
        .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        st, hl, rs, br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        lk, rt;
        logic [31:0] epc;
        logic        ehl;
        logic [1:0]  ecnt;
        logic        eovf, eudf;
    } vec_t;

    vec_t vecs[40];
    int   nvec = 0;

    task automatic add(input logic st, input logic hl, input logic rs, input logic br,
                       input logic [31:0] bt, input logic jp, input logic [31:0] jt,
                       input logic lk, input logic rt, input logic [31:0] epc,
                       input logic ehl, input logic [1:0] ecnt, input logic eovf,
                       input logic eudf);
        vecs[nvec].st = st;   vecs[nvec].hl = hl;   vecs[nvec].rs = rs;
        vecs[nvec].br = br;   vecs[nvec].bt = bt;   vecs[nvec].jp = jp;
        vecs[nvec].jt = jt;   vecs[nvec].lk = lk;   vecs[nvec].rt = rt;
        vecs[nvec].epc = epc; vecs[nvec].ehl = ehl; vecs[nvec].ecnt = ecnt;
        vecs[nvec].eovf = eovf; vecs[nvec].eudf = eudf;
        nvec++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] epc, input logic ehl,
                              input logic [1:0] ecnt, input logic eovf, input logic eudf);
        check({tag, " pc_value"}, pc_value, epc);
        check({tag, " halted"}, 32'(halted), 32'(ehl));
        check({tag, " ras_count"}, 32'(ras_count), 32'(ecnt));
        check({tag, " ras_overflow"}, 32'(ras_overflow), 32'(eovf));
        check({tag, " ras_underflow"}, 32'(ras_underflow), 32'(eudf));
    endtask

    task automatic drive_idle();
        stall = 0; is_halt = 0; resume = 0; branch_taken = 0; branch_target = 0;
        jump = 0; jump_target = 0; link = 0; ret = 0;
    endtask

    initial begin
        //   st hl rs br bt            jp jt            lk rt  epc           hl cnt ov ud
        // Four idle cycles out of reset.
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h104,      0, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h108,      0, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h10C,      0, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h110,      0, 0, 0, 0);
        // Stall at 0x20 (other inputs ignored), then aligned branch.
        add(0, 0, 0, 0, 32'h0,        1, 32'h20,       0, 0,  32'h20,       0, 0, 0, 0);
        add(1, 1, 0, 1, 32'h99,       0, 32'h0,        0, 0,  32'h20,       0, 0, 0, 0);
        add(1, 0, 0, 0, 32'h0,        1, 32'h50,       1, 1,  32'h20,       0, 0, 0, 0);
        add(0, 0, 0, 1, 32'h43,       0, 32'h0,        0, 0,  32'h40,       0, 0, 0, 0);
        // Nested call/return.
        add(0, 0, 0, 0, 32'h0,        1, 32'h10,       0, 0,  32'h10,       0, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        1, 32'h80,       1, 0,  32'h80,       0, 1, 0, 0);
        add(0, 0, 0, 0, 32'h0,        1, 32'hC0,       1, 0,  32'hC0,       0, 2, 0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,  32'h84,       0, 1, 0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,  32'h14,       0, 0, 0, 0);
        // link without jump is a plain sequential step.
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0,  32'h18,       0, 0, 0, 0);
        // Overflow: three calls into a depth-2 stack, then three returns.
        add(0, 0, 0, 0, 32'h0,        1, 32'h0,        0, 0,  32'h0,        0, 0, 0, 0);
        add(0, 0, 0, 0, 32'h0,        1, 32'h100,      1, 0,  32'h100,      0, 1, 0, 0);
        add(0, 0, 0, 0, 32'h0,        1, 32'h200,      1, 0,  32'h200,      0, 2, 0, 0);
        add(0, 0, 0, 0, 32'h0,        1, 32'h300,      1, 0,  32'h300,      0, 2, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,  32'h204,      0, 1, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,  32'h104,      0, 0, 1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,  32'h108,      0, 0, 1, 1);
        // ret beats jump+link+branch in the same cycle.
        add(0, 0, 0, 0, 32'h0,        1, 32'h400,      1, 0,  32'h400,      0, 1, 1, 1);
        add(0, 0, 0, 1, 32'h600,      1, 32'h500,      1, 1,  32'h10C,      0, 0, 1, 1);
        // Misaligned jump target, then halt beats branch.
        add(0, 0, 0, 0, 32'h0,        1, 32'h33,       0, 0,  32'h30,       0, 0, 1, 1);
        add(0, 1, 0, 1, 32'h80,       0, 32'h0,        0, 0,  32'h30,       1, 0, 1, 1);
        // HALTED ignores control and stall for five cycles.
        add(0, 0, 0, 1, 32'h80,       0, 32'h0,        0, 0,  32'h30,       1, 0, 1, 1);
        add(0, 0, 0, 0, 32'h0,        1, 32'h90,       1, 0,  32'h30,       1, 0, 1, 1);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 1,  32'h30,       1, 0, 1, 1);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h30,       1, 0, 1, 1);
        add(0, 1, 0, 1, 32'h80,       0, 32'h0,        0, 0,  32'h30,       1, 0, 1, 1);
        // resume wins over stall.
        add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0,  32'h34,       0, 0, 1, 1);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h38,       0, 0, 1, 1);
        // Wrap at the top of the address space.
        add(0, 0, 0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, 0,  32'hFFFFFFFC, 0, 0, 1, 1);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0,        0, 0, 1, 1);
        // Halt again to set up the async reset case.
        add(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0,  32'h0,        1, 0, 1, 1);

        drive_idle();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 check_regs("reset", 32'h100, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            stall = vecs[i].st; is_halt = vecs[i].hl; resume = vecs[i].rs;
            branch_taken = vecs[i].br; branch_target = vecs[i].bt;
            jump = vecs[i].jp; jump_target = vecs[i].jt;
            link = vecs[i].lk; ret = vecs[i].rt;
            #1 check($sformatf("v%0d pc_next", i), pc_next, vecs[i].epc);
            @(posedge clock);
            #1 check_regs($sformatf("v%0d", i), vecs[i].epc, vecs[i].ehl,
                          vecs[i].ecnt, vecs[i].eovf, vecs[i].eudf);
            @(negedge clock);
        end

        // Mid-cycle asynchronous reset while HALTED with both flags set.
        drive_idle();
        stall = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_regs("async reset", 32'h100, 0, 0, 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        stall   = 1'b0;
        @(posedge clock);
        #1 check_regs("after reset", 32'h104, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
